// File: rtl/conv_coeff_sched.sv
// Coefficient scheduler: streams one of BANKS stored kernels serially while vsync is high, with vs/hs/dv/pix re-timed by 2 cycles.
// Optional CONV_COEFF_CHECKSUM_EN adds coeff_sum_o, a running sum of the emitted taps.
module conv_coeff_sched #(
  parameter int COEFFW = 16,
  parameter int NTAPS  = 25,
  parameter int BANKS  = 4,
  parameter int BANK_W = 2,
  parameter int PIXW   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              dv_i,
  input  logic [PIXW-1:0]   pix_i,
  output logic              vs_o,
  output logic              hs_o,
  output logic              dv_o,
  output logic [PIXW-1:0]   pix_o,
  output logic [COEFFW-1:0] coeff_o,
  input  logic [BANK_W-1:0] bank_sel_i,
  output logic [BANK_W-1:0] active_bank_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [BANK_W-1:0] wr_bank_i,
  input  logic [4:0]        wr_idx_i,
  input  logic [COEFFW-1:0] wr_data_i,
  output logic              load_done_o,
  output logic              short_err_o,
  output logic              sel_err_o,
  input  logic              err_clr_i
`ifdef CONV_COEFF_CHECKSUM_EN
  ,
  output logic signed [COEFFW+4:0] coeff_sum_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

  localparam logic [4:0]        LAST_TAP = 5'(NTAPS - 1);
  localparam logic [4:0]        NTAPS_L  = 5'(NTAPS);
  localparam logic [BANK_W:0]   BANKS_L  = (BANK_W + 1)'(BANKS);
  localparam logic [COEFFW-1:0] UNITY    = COEFFW'(256);

  state_t              r_state, w_state_nxt;
  logic                r_vs_d1, r_hs_d1, r_dv_d1;
  logic [PIXW-1:0]     r_pix_d1;
  logic                r_vs_o, r_hs_o, r_dv_o;
  logic [PIXW-1:0]     r_pix_o;
  logic [COEFFW-1:0]   r_coeff;
  logic                r_done, r_short_err, r_sel_err;
  logic [BANK_W-1:0]   r_active;
  logic [4:0]          r_idx;
  logic [COEFFW-1:0]   r_mem [BANKS][NTAPS];

  logic                w_start, w_issue, w_last, w_short;
  logic                w_sel_ok, w_wr_ok, w_wr_en;
  logic [COEFFW-1:0]   w_tap;

  assign w_sel_ok = {1'b0, bank_sel_i} < BANKS_L;
  assign w_wr_ok  = ({1'b0, wr_bank_i} < BANKS_L) && (wr_idx_i < NTAPS_L);
  assign w_tap    = r_mem[r_active][r_idx];

  // Only the bank currently being streamed is locked against host writes.
  assign wr_ready_o = !((r_state == S_LOAD) && (wr_bank_i == r_active));
  assign w_wr_en    = wr_valid_i && wr_ready_o && w_wr_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_issue     = 1'b0;
    w_last      = 1'b0;
    w_short     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (vs_i && !r_vs_d1) begin
          w_start     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_issue = 1'b1;
        if (r_idx == LAST_TAP) begin
          w_last      = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (!vs_i) begin
          w_short     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!vs_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vs_d1     <= 1'b0;
      r_hs_d1     <= 1'b0;
      r_dv_d1     <= 1'b0;
      r_pix_d1    <= '0;
      r_vs_o      <= 1'b0;
      r_hs_o      <= 1'b0;
      r_dv_o      <= 1'b0;
      r_pix_o     <= '0;
      r_coeff     <= '0;
      r_done      <= 1'b0;
      r_short_err <= 1'b0;
      r_sel_err   <= 1'b0;
      r_active    <= '0;
      r_idx       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_vs_d1     <= vs_i;
      r_hs_d1     <= hs_i;
      r_dv_d1     <= dv_i;
      r_pix_d1    <= pix_i;
      r_vs_o      <= r_vs_d1;
      r_hs_o      <= r_hs_d1;
      r_dv_o      <= r_dv_d1;
      r_pix_o     <= r_pix_d1;
      r_coeff     <= w_issue ? w_tap : '0;
      r_done      <= w_last;
      r_short_err <= w_short | (r_short_err & ~err_clr_i);
      r_sel_err   <= (w_start & ~w_sel_ok) | (r_sel_err & ~err_clr_i);
      if (w_start) begin
        r_idx <= '0;
        if (w_sel_ok) r_active <= bank_sel_i;
      end else if (w_issue && !w_last) begin
        r_idx <= r_idx + 5'd1;
      end
    end
  end

  // Banks come out of reset as the identity kernel (1.0 at the centre tap).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++)
        for (int k = 0; k < NTAPS; k++)
          r_mem[b][k] <= (k == NTAPS / 2) ? UNITY : '0;
    end else if (w_wr_en) begin
      r_mem[wr_bank_i][wr_idx_i] <= wr_data_i;
    end
  end

`ifdef CONV_COEFF_CHECKSUM_EN
  logic signed [COEFFW+4:0] r_sum;
  always_ff @(posedge clk) begin
    if (rst)          r_sum <= '0;
    else if (w_start) r_sum <= '0;
    else if (w_issue) r_sum <= r_sum + {{5{w_tap[COEFFW-1]}}, w_tap};
  end
  assign coeff_sum_o = r_sum;
`endif

  assign vs_o          = r_vs_o;
  assign hs_o          = r_hs_o;
  assign dv_o          = r_dv_o;
  assign pix_o         = r_pix_o;
  assign coeff_o       = r_coeff;
  assign load_done_o   = r_done;
  assign active_bank_o = r_active;
  assign short_err_o   = r_short_err;
  assign sel_err_o     = r_sel_err;

endmodule

// File: tb/tb_conv_coeff_sched.sv
// Randomized bench for conv_coeff_sched: a frame-level reference model predicts every output each cycle.
module tb_conv_coeff_sched;

  localparam int COEFFW = 16;
  localparam int NTAPS  = 25;
  localparam int BANKS  = 3;
  localparam int BANK_W = 2;
  localparam int PIXW   = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              vs_i, hs_i, dv_i;
  logic [PIXW-1:0]   pix_i;
  logic              vs_o, hs_o, dv_o;
  logic [PIXW-1:0]   pix_o;
  logic [COEFFW-1:0] coeff_o;
  logic [BANK_W-1:0] bank_sel_i, active_bank_o;
  logic              wr_valid_i, wr_ready_o;
  logic [BANK_W-1:0] wr_bank_i;
  logic [4:0]        wr_idx_i;
  logic [COEFFW-1:0] wr_data_i;
  logic              load_done_o, short_err_o, sel_err_o, err_clr_i;
`ifdef CONV_COEFF_CHECKSUM_EN
  logic signed [COEFFW+4:0] coeff_sum_o;
`endif

  always #5 clk = ~clk;

  conv_coeff_sched #(
    .COEFFW(COEFFW), .NTAPS(NTAPS), .BANKS(BANKS), .BANK_W(BANK_W), .PIXW(PIXW)
  ) dut (
    .clk(clk), .rst(rst),
    .vs_i(vs_i), .hs_i(hs_i), .dv_i(dv_i), .pix_i(pix_i),
    .vs_o(vs_o), .hs_o(hs_o), .dv_o(dv_o), .pix_o(pix_o),
    .coeff_o(coeff_o), .bank_sel_i(bank_sel_i), .active_bank_o(active_bank_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_bank_i(wr_bank_i),
    .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
    .load_done_o(load_done_o), .short_err_o(short_err_o), .sel_err_o(sel_err_o),
    .err_clr_i(err_clr_i)
`ifdef CONV_COEFF_CHECKSUM_EN
    , .coeff_sum_o(coeff_sum_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: kernel store, a snapshot of the kernel being streamed, and
  // the position within the current frame's tap stream.
  logic [15:0]     m_mem [BANKS][NTAPS];
  logic [15:0]     m_snap [NTAPS];
  int              m_act, m_n, m_sum;
  bit              m_load, m_hold, m_short, m_sel;
  logic            p_vs, p_hs, p_dv;
  logic [PIXW-1:0] p_pix;
  logic            e_vs, e_hs, e_dv, e_done;
  logic [PIXW-1:0] e_pix;
  logic [15:0]     e_coeff;

  task automatic model_edge();
    bit rdy, rise, short_set;
    if (rst) begin
      for (int b = 0; b < BANKS; b++)
        for (int k = 0; k < NTAPS; k++)
          m_mem[b][k] = (k == 12) ? 16'h0100 : 16'h0000;
      m_act = 0; m_n = 0; m_sum = 0;
      m_load = 0; m_hold = 0; m_short = 0; m_sel = 0;
      p_vs = 0; p_hs = 0; p_dv = 0; p_pix = '0;
      e_vs = 0; e_hs = 0; e_dv = 0; e_pix = '0; e_coeff = '0; e_done = 0;
      return;
    end
    rdy = !(m_load && int'(wr_bank_i) == m_act);
    e_vs = p_vs; e_hs = p_hs; e_dv = p_dv; e_pix = p_pix;
    e_coeff = '0; e_done = 0; rise = 0; short_set = 0;
    if (m_load) begin
      e_coeff = m_snap[m_n];
      m_sum += int'($signed(e_coeff));
      if (m_n == NTAPS - 1) begin
        e_done = 1; m_load = 0; m_hold = 1;
      end else if (!vs_i) begin
        m_load = 0; short_set = 1;
      end
      m_n++;
    end else if (m_hold) begin
      if (!vs_i) m_hold = 0;
    end else begin
      rise = vs_i && !p_vs;
    end
    if (err_clr_i) begin m_short = 0; m_sel = 0; end
    if (short_set) m_short = 1;
    if (wr_valid_i && rdy && int'(wr_bank_i) < BANKS && int'(wr_idx_i) < NTAPS)
      m_mem[wr_bank_i][wr_idx_i] = wr_data_i;
    if (rise) begin
      if (int'(bank_sel_i) < BANKS) m_act = int'(bank_sel_i);
      else m_sel = 1;
      for (int k = 0; k < NTAPS; k++) m_snap[k] = m_mem[m_act][k];
      m_load = 1; m_n = 0; m_sum = 0;
    end
    p_vs = vs_i; p_hs = hs_i; p_dv = dv_i; p_pix = pix_i;
  endtask

  task automatic step();
    #1;
    check("wr_ready", 32'(wr_ready_o), 32'(!(m_load && int'(wr_bank_i) == m_act)));
    @(posedge clk);
    model_edge();
    #1;
    check("vs_o", 32'(vs_o), 32'(e_vs));
    check("hs_o", 32'(hs_o), 32'(e_hs));
    check("dv_o", 32'(dv_o), 32'(e_dv));
    check("pix_o", 32'(pix_o), 32'(e_pix));
    check("coeff_o", 32'(coeff_o), 32'(e_coeff));
    check("load_done", 32'(load_done_o), 32'(e_done));
    check("active_bank", 32'(active_bank_o), 32'(m_act));
    check("short_err", 32'(short_err_o), 32'(m_short));
    check("sel_err", 32'(sel_err_o), 32'(m_sel));
`ifdef CONV_COEFF_CHECKSUM_EN
    check("coeff_sum", 32'(int'(coeff_sum_o)), 32'(m_sum));
`endif
    hs_i = 1'($urandom); dv_i = 1'($urandom); pix_i = PIXW'($urandom);
  endtask

  task automatic frame(input int len, input int gap, input int sel, input bit rnd);
    bank_sel_i = BANK_W'(sel);
    for (int c = 0; c < len + gap; c++) begin
      vs_i = (c < len);
      if (rnd) begin
        wr_valid_i = 1'($urandom);
        wr_bank_i  = BANK_W'($urandom);
        wr_idx_i   = 5'($urandom);
        wr_data_i  = COEFFW'($urandom);
        err_clr_i  = ($urandom_range(0, 7) == 0);
        rst        = ($urandom_range(0, 299) == 0);
      end
      step();
    end
  endtask

  initial begin
    rst = 1; vs_i = 0; hs_i = 0; dv_i = 0; pix_i = '0; bank_sel_i = '0;
    wr_valid_i = 0; wr_bank_i = '0; wr_idx_i = '0; wr_data_i = '0; err_clr_i = 0;
    @(posedge clk);
    model_edge();
    #1;
    repeat (3) step();
    rst = 0;
    repeat (4) step();

    // Identity kernel after reset.
    frame(40, 4, 0, 0);

    // Ramp kernel in bank 2.
    for (int k = 0; k < NTAPS; k++) begin
      wr_valid_i = 1; wr_bank_i = 2'd2; wr_idx_i = 5'(k); wr_data_i = 16'(16 * k);
      step();
    end
    wr_valid_i = 0;
    frame(30, 4, 2, 0);

    // Short vsync window, then clear.
    frame(10, 4, 2, 0);
    err_clr_i = 1; step(); err_clr_i = 0; step();

    // Streaming bank 1 while the host alternates writes to bank 1 and bank 0.
    bank_sel_i = 2'd1;
    vs_i = 1;
    for (int c = 0; c < 30; c++) begin
      wr_valid_i = 1;
      wr_bank_i  = (c % 2 == 1) ? 2'd0 : 2'd1;
      wr_idx_i   = 5'($urandom_range(0, NTAPS - 1));
      wr_data_i  = COEFFW'($urandom);
      step();
    end
    vs_i = 0; wr_valid_i = 0;
    repeat (4) step();

    // Out-of-range bank select keeps bank 1.
    frame(28, 4, 3, 0);
    err_clr_i = 1; step(); err_clr_i = 0;

    for (int f = 0; f < 30; f++)
      frame($urandom_range(1, 40), $urandom_range(1, 5), $urandom_range(0, 3), 1);

    rst = 0; wr_valid_i = 0; err_clr_i = 0; vs_i = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
